// File: rtl/wb_writeback_stage_pkg.sv
// Shared encodings for the writeback stage: load-size codes and fixed register numbers.
package wb_writeback_stage_pkg;

  // Load size selector carried in WB_BitsIn.
  localparam logic [1:0] BITSIN_WORD   = 2'b00;
  localparam logic [1:0] BITSIN_HALF_S = 2'b01;
  localparam logic [1:0] BITSIN_BYTE_S = 2'b10;
  localparam logic [1:0] BITSIN_BYTE_U = 2'b11;

  // Architectural register numbers with special meaning at writeback.
  localparam logic [4:0] REG_RA   = 5'd31;
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Source chosen for the register-file write data.
  typedef enum logic [1:0] {
    SrcAlu,
    SrcLoad,
    SrcHiLo,
    SrcPcAdd4
  } rf_src_e;

endpackage

// File: rtl/wb_writeback_stage_sad_min_tracker.sv
// Running minimum SAD search: keeps the smallest sample, its tag and a saturating sample count.
module wb_writeback_stage_sad_min_tracker
  import wb_writeback_stage_pkg::*;
#(
  parameter int unsigned DW    = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             sample_valid,
  input  logic [DW-1:0]    sample_sad,
  input  logic [DW-1:0]    sample_tag,
  input  logic             clear,
  output logic [DW-1:0]    min_sad,
  output logic [DW-1:0]    min_tag,
  output logic             min_valid,
  output logic [CNT_W-1:0] sad_count
);

  logic [DW-1:0]    min_sad_q, min_sad_d;
  logic [DW-1:0]    min_tag_q, min_tag_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] count_q, count_d;

  // State as seen by an incoming sample: a same-cycle clear is applied first.
  logic             base_valid;
  logic [DW-1:0]    base_sad;
  logic [DW-1:0]    base_tag;
  logic [CNT_W-1:0] base_count;

  // Next-state: clear, then compare/update and count the sample.
  always_comb begin
    base_valid = clear ? 1'b0 : valid_q;
    base_sad   = clear ? '0 : min_sad_q;
    base_tag   = clear ? '0 : min_tag_q;
    base_count = clear ? '0 : count_q;

    min_sad_d = base_sad;
    min_tag_d = base_tag;
    valid_d   = base_valid;
    count_d   = base_count;

    if (sample_valid) begin
      valid_d = 1'b1;
      // Strict compare so ties keep the earlier sample.
      if (!base_valid || (sample_sad < base_sad)) begin
        min_sad_d = sample_sad;
        min_tag_d = sample_tag;
      end
      if (base_count != {CNT_W{1'b1}}) begin
        count_d = base_count + CNT_W'(1);
      end
    end
  end

  // Tracker registers; reset overrides any clear or sample.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      min_sad_q <= '0;
      min_tag_q <= '0;
      valid_q   <= 1'b0;
      count_q   <= '0;
    end else begin
      min_sad_q <= min_sad_d;
      min_tag_q <= min_tag_d;
      valid_q   <= valid_d;
      count_q   <= count_d;
    end
  end

  assign min_sad   = min_sad_q;
  assign min_tag   = min_tag_q;
  assign min_valid = valid_q;
  assign sad_count = count_q;

endmodule

// File: rtl/wb_writeback_stage.sv
// Final pipeline stage: register-file write mux, architectural HI/LO and the SAD min tracker.
module wb_writeback_stage
  import wb_writeback_stage_pkg::*;
#(
  parameter int unsigned DW    = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [DW-1:0]    WB_PCAdd4,
  input  logic [DW-1:0]    WB_DataMemOut,
  input  logic [DW-1:0]    WB_ALUOut,
  input  logic [2*DW-1:0]  WB_MaddOut,
  input  logic [DW-1:0]    WB_HiLoOut,
  input  logic [4:0]       WB_WriteRegCarry,
  input  logic             WB_MemToReg,
  input  logic             WB_Jal_Mux,
  input  logic             WB_HiLo_WB,
  input  logic             WB_RegWrite,
  input  logic             WB_SEL_Madd,
  input  logic [1:0]       WB_BitsIn,
  input  logic             WB_WriteDataHi,
  input  logic             WB_WriteDataLo,
  input  logic [DW-1:0]    WB_sad_add_d0_out,
  input  logic [DW-1:0]    WB_minVal,
  input  logic             WB_minRegWrite,
  input  logic             WB_MinClear,
  output logic             RF_WriteEn,
  output logic [4:0]       RF_WriteAddr,
  output logic [DW-1:0]    RF_WriteData,
  output logic [DW-1:0]    Hi_Out,
  output logic [DW-1:0]    Lo_Out,
  output logic [DW-1:0]    Min_SAD,
  output logic [DW-1:0]    Min_Tag,
  output logic             Min_Valid,
  output logic [CNT_W-1:0] Sad_Count
);

  rf_src_e       rf_src;
  logic [DW-1:0] load_data;
  logic [DW-1:0] hi_q, hi_d;
  logic [DW-1:0] lo_q, lo_d;

  // Sized load from the low lane; alignment already done upstream.
  always_comb begin
    load_data = WB_DataMemOut;
    case (WB_BitsIn)
      BITSIN_WORD:   load_data = WB_DataMemOut;
      BITSIN_HALF_S: load_data = {{(DW-16){WB_DataMemOut[15]}}, WB_DataMemOut[15:0]};
      BITSIN_BYTE_S: load_data = {{(DW-8){WB_DataMemOut[7]}}, WB_DataMemOut[7:0]};
      BITSIN_BYTE_U: load_data = {{(DW-8){1'b0}}, WB_DataMemOut[7:0]};
      default:       load_data = WB_DataMemOut;
    endcase
  end

  // Write-data source priority: jal, then mfhi/mflo, then load, then ALU.
  always_comb begin
    rf_src = SrcAlu;
    if (WB_Jal_Mux) begin
      rf_src = SrcPcAdd4;
    end else if (WB_HiLo_WB) begin
      rf_src = SrcHiLo;
    end else if (WB_MemToReg) begin
      rf_src = SrcLoad;
    end
  end

  // Register-file write port, purely combinational.
  always_comb begin
    RF_WriteData = WB_ALUOut;
    case (rf_src)
      SrcPcAdd4: RF_WriteData = WB_PCAdd4;
      SrcHiLo:   RF_WriteData = WB_HiLoOut;
      SrcLoad:   RF_WriteData = load_data;
      SrcAlu:    RF_WriteData = WB_ALUOut;
      default:   RF_WriteData = WB_ALUOut;
    endcase
    RF_WriteAddr = WB_Jal_Mux ? REG_RA : WB_WriteRegCarry;
    // r0 is hardwired, so never request a write to it.
    RF_WriteEn   = WB_RegWrite && (RF_WriteAddr != REG_ZERO);
  end

  // HI/LO next-state: madd result halves or ALU result, per-half enables.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (WB_SEL_Madd) begin
      if (WB_WriteDataHi) hi_d = WB_MaddOut[2*DW-1:DW];
      if (WB_WriteDataLo) lo_d = WB_MaddOut[DW-1:0];
    end else begin
      if (WB_WriteDataHi) hi_d = WB_ALUOut;
      if (WB_WriteDataLo) lo_d = WB_ALUOut;
    end
  end

  // HI/LO registers; no bypass, readers see the update a cycle later.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign Hi_Out = hi_q;
  assign Lo_Out = lo_q;

  wb_writeback_stage_sad_min_tracker #(
    .DW    (DW),
    .CNT_W (CNT_W)
  ) u_sad_min_tracker (
    .Clk          (Clk),
    .Reset        (Reset),
    .sample_valid (WB_minRegWrite),
    .sample_sad   (WB_sad_add_d0_out),
    .sample_tag   (WB_minVal),
    .clear        (WB_MinClear),
    .min_sad      (Min_SAD),
    .min_tag      (Min_Tag),
    .min_valid    (Min_Valid),
    .sad_count    (Sad_Count)
  );

endmodule

// File: tb/tb_wb_writeback_stage.sv
// Self-checking bench for wb_writeback_stage against a queue-based reference model.
module tb_wb_writeback_stage;

  localparam int unsigned DW    = 32;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned CMAX  = (1 << CNT_W) - 1;

  logic             Clk = 1'b0;
  logic             Reset;
  logic [DW-1:0]    WB_PCAdd4, WB_DataMemOut, WB_ALUOut, WB_HiLoOut;
  logic [2*DW-1:0]  WB_MaddOut;
  logic [4:0]       WB_WriteRegCarry;
  logic             WB_MemToReg, WB_Jal_Mux, WB_HiLo_WB, WB_RegWrite, WB_SEL_Madd;
  logic [1:0]       WB_BitsIn;
  logic             WB_WriteDataHi, WB_WriteDataLo;
  logic [DW-1:0]    WB_sad_add_d0_out, WB_minVal;
  logic             WB_minRegWrite, WB_MinClear;
  logic             RF_WriteEn;
  logic [4:0]       RF_WriteAddr;
  logic [DW-1:0]    RF_WriteData, Hi_Out, Lo_Out, Min_SAD, Min_Tag;
  logic             Min_Valid;
  logic [CNT_W-1:0] Sad_Count;

  int errors = 0;
  int checks = 0;

  // Reference model state: HI/LO values and every sample since the last clear/reset.
  logic [DW-1:0] m_hi, m_lo;
  logic [DW-1:0] sad_q[$];
  logic [DW-1:0] tag_q[$];

  always #5 Clk = ~Clk;

  wb_writeback_stage #(.DW(DW), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Reset(Reset),
    .WB_PCAdd4(WB_PCAdd4), .WB_DataMemOut(WB_DataMemOut), .WB_ALUOut(WB_ALUOut),
    .WB_MaddOut(WB_MaddOut), .WB_HiLoOut(WB_HiLoOut), .WB_WriteRegCarry(WB_WriteRegCarry),
    .WB_MemToReg(WB_MemToReg), .WB_Jal_Mux(WB_Jal_Mux), .WB_HiLo_WB(WB_HiLo_WB),
    .WB_RegWrite(WB_RegWrite), .WB_SEL_Madd(WB_SEL_Madd), .WB_BitsIn(WB_BitsIn),
    .WB_WriteDataHi(WB_WriteDataHi), .WB_WriteDataLo(WB_WriteDataLo),
    .WB_sad_add_d0_out(WB_sad_add_d0_out), .WB_minVal(WB_minVal),
    .WB_minRegWrite(WB_minRegWrite), .WB_MinClear(WB_MinClear),
    .RF_WriteEn(RF_WriteEn), .RF_WriteAddr(RF_WriteAddr), .RF_WriteData(RF_WriteData),
    .Hi_Out(Hi_Out), .Lo_Out(Lo_Out), .Min_SAD(Min_SAD), .Min_Tag(Min_Tag),
    .Min_Valid(Min_Valid), .Sad_Count(Sad_Count)
  );

  // Model: minimum is the first smallest sample in arrival order.
  function automatic int first_min_index();
    int best = 0;
    for (int i = 1; i < sad_q.size(); i++) if (sad_q[i] < sad_q[best]) best = i;
    return best;
  endfunction

  function automatic logic [DW-1:0] exp_min_sad();
    return (sad_q.size() == 0) ? '0 : sad_q[first_min_index()];
  endfunction

  function automatic logic [DW-1:0] exp_min_tag();
    return (tag_q.size() == 0) ? '0 : tag_q[first_min_index()];
  endfunction

  function automatic logic [CNT_W-1:0] exp_count();
    return (sad_q.size() > CMAX) ? CNT_W'(CMAX) : CNT_W'(sad_q.size());
  endfunction

  // Model of the register-file write data from the instruction-level rules.
  function automatic logic [DW-1:0] exp_rf_data();
    shortint h;
    byte     b;
    h = WB_DataMemOut[15:0];
    b = WB_DataMemOut[7:0];
    if (WB_Jal_Mux) return WB_PCAdd4;
    if (WB_HiLo_WB) return WB_HiLoOut;
    if (WB_MemToReg) begin
      case (WB_BitsIn)
        2'd0:    return WB_DataMemOut;
        2'd1:    return DW'(int'(h));
        2'd2:    return DW'(int'(b));
        default: return WB_DataMemOut & 32'h0000_00FF;
      endcase
    end
    return WB_ALUOut;
  endfunction

  task automatic idle_inputs();
    WB_PCAdd4 = '0; WB_DataMemOut = '0; WB_ALUOut = '0; WB_MaddOut = '0; WB_HiLoOut = '0;
    WB_WriteRegCarry = '0; WB_MemToReg = 0; WB_Jal_Mux = 0; WB_HiLo_WB = 0; WB_RegWrite = 0;
    WB_SEL_Madd = 0; WB_BitsIn = '0; WB_WriteDataHi = 0; WB_WriteDataLo = 0;
    WB_sad_add_d0_out = '0; WB_minVal = '0; WB_minRegWrite = 0; WB_MinClear = 0;
  endtask

  // Advance the model with the currently driven inputs, then take one clock edge.
  task automatic clock_edge();
    if (Reset) begin
      m_hi = '0; m_lo = '0;
      sad_q.delete(); tag_q.delete();
    end else begin
      if (WB_WriteDataHi) m_hi = WB_SEL_Madd ? WB_MaddOut[63:32] : WB_ALUOut;
      if (WB_WriteDataLo) m_lo = WB_SEL_Madd ? WB_MaddOut[31:0] : WB_ALUOut;
      if (WB_MinClear) begin
        sad_q.delete(); tag_q.delete();
      end
      if (WB_minRegWrite) begin
        sad_q.push_back(WB_sad_add_d0_out);
        tag_q.push_back(WB_minVal);
      end
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic sample(input logic [DW-1:0] sad, input logic [DW-1:0] tag, input logic clr);
    WB_sad_add_d0_out = sad; WB_minVal = tag; WB_minRegWrite = 1; WB_MinClear = clr;
    clock_edge();
    WB_minRegWrite = 0; WB_MinClear = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    Reset = 1;
    repeat (3) clock_edge();
    checks++; if (Hi_Out !== 0) begin errors++; $display("FAIL reset_hi got=%h exp=0", Hi_Out); end
    checks++; if (Lo_Out !== 0) begin errors++; $display("FAIL reset_lo got=%h exp=0", Lo_Out); end
    checks++; if (Min_SAD !== 0) begin errors++; $display("FAIL reset_minsad got=%h exp=0", Min_SAD); end
    checks++; if (Min_Tag !== 0) begin errors++; $display("FAIL reset_mintag got=%h exp=0", Min_Tag); end
    checks++; if (Sad_Count !== 0) begin errors++; $display("FAIL reset_count got=%0d exp=0", Sad_Count); end
    checks++; if (Min_Valid !== 0) begin errors++; $display("FAIL reset_valid got=%b exp=0", Min_Valid); end
    checks++; if (RF_WriteEn !== 0) begin errors++; $display("FAIL reset_rfen got=%b exp=0", RF_WriteEn); end
    Reset = 0;
    clock_edge();
  endtask

  task automatic test_load_paths();
    logic [DW-1:0] exp_tab[4];
    exp_tab[0] = 32'h1234_F08C; exp_tab[1] = 32'hFFFF_F08C;
    exp_tab[2] = 32'hFFFF_FF8C; exp_tab[3] = 32'h0000_008C;
    idle_inputs();
    WB_DataMemOut = 32'h1234_F08C; WB_ALUOut = 32'hAAAA_5555;
    WB_MemToReg = 1; WB_RegWrite = 1; WB_WriteRegCarry = 5'd9;
    for (int i = 0; i < 4; i++) begin
      WB_BitsIn = 2'(i);
      #1;
      checks++;
      if (RF_WriteData !== exp_tab[i]) begin
        errors++; $display("FAIL load_bits%0d got=%h exp=%h", i, RF_WriteData, exp_tab[i]);
      end
    end
    checks++;
    if (RF_WriteEn !== 1 || RF_WriteAddr !== 5'd9) begin
      errors++; $display("FAIL load_addr got=%b/%0d exp=1/9", RF_WriteEn, RF_WriteAddr);
    end
    // BitsIn is irrelevant without MemToReg.
    WB_MemToReg = 0; WB_BitsIn = 2'd2;
    #1;
    checks++;
    if (RF_WriteData !== 32'hAAAA_5555) begin
      errors++; $display("FAIL alu_path got=%h exp=aaaa5555", RF_WriteData);
    end
  endtask

  task automatic test_jal_r0();
    idle_inputs();
    WB_PCAdd4 = 32'h40; WB_Jal_Mux = 1; WB_RegWrite = 1; WB_HiLo_WB = 1; WB_MemToReg = 1;
    WB_WriteRegCarry = 5'd4;
    #1;
    checks++;
    if (RF_WriteAddr !== 5'd31 || RF_WriteData !== 32'h40 || RF_WriteEn !== 1) begin
      errors++;
      $display("FAIL jal got=%0d/%h/%b exp=31/40/1", RF_WriteAddr, RF_WriteData, RF_WriteEn);
    end
    WB_Jal_Mux = 0; WB_WriteRegCarry = 5'd0;
    #1;
    checks++;
    if (RF_WriteEn !== 0) begin errors++; $display("FAIL r0_write got=%b exp=0", RF_WriteEn); end
  endtask

  task automatic test_hilo();
    idle_inputs();
    WB_MaddOut = 64'hDEAD_BEEF_0000_0001; WB_SEL_Madd = 1;
    WB_WriteDataHi = 1; WB_WriteDataLo = 1;
    #1;
    checks++;
    if (Hi_Out === 32'hDEADBEEF) begin errors++; $display("FAIL hilo_bypass got=%h exp=old", Hi_Out); end
    clock_edge();
    checks++;
    if (Hi_Out !== 32'hDEADBEEF || Lo_Out !== 32'h1) begin
      errors++; $display("FAIL madd got=%h_%h exp=deadbeef_00000001", Hi_Out, Lo_Out);
    end
    idle_inputs();
    WB_ALUOut = 32'd7; WB_WriteDataLo = 1;
    clock_edge();
    checks++;
    if (Hi_Out !== 32'hDEADBEEF || Lo_Out !== 32'd7) begin
      errors++; $display("FAIL mtlo got=%h_%h exp=deadbeef_00000007", Hi_Out, Lo_Out);
    end
    // Madd with only the HI enable writes just the upper half.
    idle_inputs();
    WB_MaddOut = 64'h1111_2222_3333_4444; WB_SEL_Madd = 1; WB_WriteDataHi = 1;
    clock_edge();
    checks++;
    if (Hi_Out !== 32'h11112222 || Lo_Out !== 32'd7) begin
      errors++; $display("FAIL madd_hi got=%h_%h exp=11112222_00000007", Hi_Out, Lo_Out);
    end
    idle_inputs();
  endtask

  task automatic test_min_tracker();
    logic [DW-1:0] sads[4];
    logic [DW-1:0] tags[4];
    sads[0] = 50; sads[1] = 30; sads[2] = 30; sads[3] = 70;
    tags[0] = 0;  tags[1] = 4;  tags[2] = 8;  tags[3] = 12;
    idle_inputs();
    sample(32'd99, 32'd99, 1'b1);
    WB_MinClear = 1;
    clock_edge();
    WB_MinClear = 0;
    checks++;
    if (Min_Valid !== 0 || Sad_Count !== 0 || Min_SAD !== 0) begin
      errors++; $display("FAIL clear_alone got=%b/%0d/%0d exp=0/0/0", Min_Valid, Sad_Count, Min_SAD);
    end
    for (int i = 0; i < 4; i++) sample(sads[i], tags[i], 1'b0);
    checks++;
    if (Min_SAD !== 30 || Min_Tag !== 4 || Sad_Count !== 4 || Min_Valid !== 1) begin
      errors++;
      $display("FAIL min_seq got=%0d/%0d/%0d/%b exp=30/4/4/1", Min_SAD, Min_Tag, Sad_Count, Min_Valid);
    end
    sample(32'd9, 32'd3, 1'b1);
    checks++;
    if (Min_SAD !== 9 || Min_Tag !== 3 || Sad_Count !== 1 || Min_Valid !== 1) begin
      errors++;
      $display("FAIL clear_sample got=%0d/%0d/%0d/%b exp=9/3/1/1", Min_SAD, Min_Tag, Sad_Count, Min_Valid);
    end
    // A later larger sample after clear must not displace the first.
    sample(32'd20, 32'd5, 1'b0);
    checks++;
    if (Min_SAD !== 9 || Min_Tag !== 3 || Sad_Count !== 2) begin
      errors++; $display("FAIL after_clear got=%0d/%0d/%0d exp=9/3/2", Min_SAD, Min_Tag, Sad_Count);
    end
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    sample(32'd4, 32'd1, 1'b0);
    Reset = 1; WB_minRegWrite = 1; WB_sad_add_d0_out = 32'd2; WB_minVal = 32'd2;
    clock_edge();
    Reset = 0; WB_minRegWrite = 0;
    checks++;
    if (Min_SAD !== 0 || Min_Tag !== 0 || Sad_Count !== 0 || Min_Valid !== 0 || Hi_Out !== 0) begin
      errors++;
      $display("FAIL reset_mid got=%0d/%0d/%0d/%b/%h exp=0/0/0/0/0",
               Min_SAD, Min_Tag, Sad_Count, Min_Valid, Hi_Out);
    end
  endtask

  task automatic test_saturation();
    idle_inputs();
    WB_MinClear = 1;
    clock_edge();
    WB_MinClear = 0;
    for (int i = 0; i < (1 << CNT_W) + 2; i++) begin
      sample(DW'($urandom_range(5, 200)), DW'(i), 1'b0);
      if (i == CMAX - 2) begin
        checks++;
        if (Sad_Count !== exp_count()) begin
          errors++; $display("FAIL count_pre_sat got=%0d exp=%0d", Sad_Count, exp_count());
        end
      end
    end
    checks++;
    if (Sad_Count !== CNT_W'(CMAX)) begin
      errors++; $display("FAIL count_sat got=%0d exp=%0d", Sad_Count, CMAX);
    end
    checks++;
    if (Min_SAD !== exp_min_sad() || Min_Tag !== exp_min_tag()) begin
      errors++;
      $display("FAIL sat_min got=%0d/%0d exp=%0d/%0d", Min_SAD, Min_Tag, exp_min_sad(), exp_min_tag());
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      WB_PCAdd4 = $urandom; WB_DataMemOut = $urandom; WB_ALUOut = $urandom;
      WB_MaddOut = {$urandom, $urandom}; WB_HiLoOut = $urandom;
      WB_WriteRegCarry = 5'($urandom); WB_MemToReg = 1'($urandom); WB_Jal_Mux = ($urandom_range(0, 3) == 0);
      WB_HiLo_WB = 1'($urandom); WB_RegWrite = 1'($urandom); WB_SEL_Madd = 1'($urandom);
      WB_BitsIn = 2'($urandom); WB_WriteDataHi = 1'($urandom); WB_WriteDataLo = 1'($urandom);
      WB_sad_add_d0_out = DW'($urandom_range(0, 15)); WB_minVal = $urandom;
      WB_minRegWrite = 1'($urandom); WB_MinClear = ($urandom_range(0, 7) == 0);
      if (n < 8) WB_WriteRegCarry = 5'd0;
      #1;
      checks++;
      if (RF_WriteData !== exp_rf_data()) begin
        errors++; $display("FAIL rnd_rfdata n=%0d got=%h exp=%h", n, RF_WriteData, exp_rf_data());
      end
      checks++;
      if (RF_WriteAddr !== (WB_Jal_Mux ? 5'd31 : WB_WriteRegCarry) ||
          RF_WriteEn !== (WB_RegWrite && (WB_Jal_Mux || WB_WriteRegCarry != 0))) begin
        errors++; $display("FAIL rnd_rfaddr n=%0d got=%0d/%b", n, RF_WriteAddr, RF_WriteEn);
      end
      clock_edge();
      checks++;
      if (Hi_Out !== m_hi || Lo_Out !== m_lo) begin
        errors++; $display("FAIL rnd_hilo n=%0d got=%h_%h exp=%h_%h", n, Hi_Out, Lo_Out, m_hi, m_lo);
      end
      checks++;
      if (Min_SAD !== exp_min_sad() || Min_Tag !== exp_min_tag() ||
          Sad_Count !== exp_count() || Min_Valid !== (sad_q.size() != 0)) begin
        errors++;
        $display("FAIL rnd_min n=%0d got=%0d/%h/%0d/%b exp=%0d/%h/%0d/%b", n, Min_SAD, Min_Tag,
                 Sad_Count, Min_Valid, exp_min_sad(), exp_min_tag(), exp_count(), sad_q.size() != 0);
      end
    end
    idle_inputs();
  endtask

  initial begin
    m_hi = '0; m_lo = '0;
    Reset = 1;
    idle_inputs();
    test_reset();
    test_load_paths();
    test_jal_r0();
    test_hilo();
    test_min_tracker();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
